// File: rtl/line_window_3x3_pkg.sv
// rtl/line_window_3x3_pkg.sv - shared defaults, coordinate types and window indexing
// Purpose: default geometry and pixel width, the coordinate type used for
//          col/row, and the window index helper (k = 3*r + c).
// Ports:   none (package).
package line_window_3x3_pkg;

  localparam int PIXEL_SIZE         = 7;
  localparam int PW_DEFAULT         = PIXEL_SIZE + 1;
  localparam int IMG_WIDTH_DEFAULT  = 640;
  localparam int IMG_HEIGHT_DEFAULT = 480;

  typedef logic [15:0] coord_t;

  typedef struct packed {
    coord_t row;
    coord_t col;
  } pos_t;

  // Flat index of window pixel (r, c); r=0 oldest line, c=0 oldest column.
  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/line_window_3x3_line_fifo.sv
// rtl/line_window_3x3_line_fifo.sv - fixed-length pixel delay line for one image row
// Purpose: delays the accepted pixel stream by exactly DEPTH accepted pixels.
//          Storage is a RAM with a single wrap-around address; the slot about
//          to be overwritten holds the pixel written DEPTH accepts earlier.
// Ports:   clk  - clock
//          en   - advance the delay line by one pixel
//          din  - pixel in
//          dout - pixel accepted DEPTH en-cycles ago (valid while en=1)
module line_fifo #(
  parameter int PW    = 8,
  parameter int DEPTH = 640
) (
  input  logic          clk,
  input  logic          en,
  input  logic [PW-1:0] din,
  output logic [PW-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] addr;

  // Read-before-write on the same slot gives a delay of exactly DEPTH.
  assign dout = mem[addr];

  // No reset: the delay is independent of the starting address, and the
  // >= compare pulls any out-of-range power-up value back into range.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= din;
      if (addr >= ADDR_LAST) addr <= '0;
      else                   addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/line_window_3x3.sv
// rtl/line_window_3x3.sv - raster stream to 3x3 neighbourhood window
// Purpose: buffers two image lines and presents a 3x3 window of the stream,
//          flagging windows that lie fully inside the frame.
// Ports:   clk        - clock, all state on posedge
//          reset      - asynchronous active-high, clears control state/outputs
//          en         - pixel valid, data accepted on posedge when high
//          data       - input pixel, raster order
//          window     - 9*PW, pixel k=3*r+c at [k*PW +: PW], k=8 newest
//          win_valid  - window is a complete in-frame neighbourhood
//          col, row   - position of the newest pixel in window
//          frame_done - one-cycle pulse after the last pixel of a frame
module line_window_3x3
  import line_window_3x3_pkg::*;
#(
  parameter int PW         = PW_DEFAULT,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [PW-1:0]   data,
  output logic [9*PW-1:0] window,
  output logic            win_valid,
  output logic [15:0]     col,
  output logic [15:0]     row,
  output logic            frame_done
);

  localparam coord_t COL_LAST   = coord_t'(IMG_WIDTH - 1);
  localparam coord_t ROW_LAST   = coord_t'(IMG_HEIGHT - 1);
  localparam coord_t FIRST_FULL = coord_t'(2);

  logic [PW-1:0] fifo0_out;
  logic [PW-1:0] fifo1_out;
  logic [PW-1:0] win [3][3];
  pos_t          cnt;  // position the next accepted pixel will take

  line_fifo #(.PW(PW), .DEPTH(IMG_WIDTH)) u_fifo0 (
    .clk  (clk),
    .en   (en),
    .din  (data),
    .dout (fifo0_out)
  );

  line_fifo #(.PW(PW), .DEPTH(IMG_WIDTH)) u_fifo1 (
    .clk  (clk),
    .en   (en),
    .din  (fifo0_out),
    .dout (fifo1_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      cnt        <= '0;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (en) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 2; c++)
          win[r][c] <= win[r][c+1];
      win[0][2] <= fifo1_out;
      win[1][2] <= fifo0_out;
      win[2][2] <= data;

      col <= cnt.col;
      row <= cnt.row;
      // Columns 0/1 would pull in the tail of the previous line, rows 0/1
      // would pull in stale line-buffer contents (previous frame).
      win_valid  <= (cnt.col >= FIRST_FULL) && (cnt.row >= FIRST_FULL);
      frame_done <= (cnt.col == COL_LAST) && (cnt.row == ROW_LAST);

      if (cnt.col == COL_LAST) begin
        cnt.col <= '0;
        if (cnt.row == ROW_LAST) cnt.row <= '0;
        else                     cnt.row <= cnt.row + 1'b1;
      end else begin
        cnt.col <= cnt.col + 1'b1;
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign window[win_idx(r, c)*PW +: PW] = win[r][c];
    end
  end

endmodule

// File: tb/tb_line_window_3x3.sv
// tb/tb_line_window_3x3.sv - self-checking bench for line_window_3x3 on a 4x4 frame
module tb_line_window_3x3;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic            clk;
  logic            reset;
  logic            en;
  logic [PW-1:0]   data;
  logic [9*PW-1:0] window;
  logic            win_valid;
  logic [15:0]     col;
  logic [15:0]     row;
  logic            frame_done;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0]  pix;
    logic        vld;
    logic [15:0] col;
    logic [15:0] row;
    logic        fd;
    logic [71:0] win;
  } vec_t;

  vec_t tbl [W*H];

  line_window_3x3 #(.PW(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .data       (data),
    .window     (window),
    .win_valid  (win_valid),
    .col        (col),
    .row        (row),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [71:0] mk_win(input int p0, input int p1, input int p2,
                                         input int p3, input int p4, input int p5,
                                         input int p6, input int p7, input int p8);
    return {8'(p8), 8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  // Streams one 4x4 frame; with gaps, every third cycle is an en=0 cycle.
  task automatic run_frame(input string tag, input bit gaps);
    int cyc = 0;
    int nvalid = 0;
    logic [15:0] pc = 0, pr = 0;
    for (int p = 0; p < W*H; p++) begin
      if (gaps && (cyc % 3 == 2)) begin
        en = 1'b0;
        @(negedge clk);
        check({tag, " gap win_valid"}, 72'(win_valid), 72'(0));
        check({tag, " gap frame_done"}, 72'(frame_done), 72'(0));
        check({tag, " gap col hold"}, 72'(col), 72'(pc));
        check({tag, " gap row hold"}, 72'(row), 72'(pr));
        cyc++;
      end
      en   = 1'b1;
      data = tbl[p].pix;
      @(negedge clk);
      cyc++;
      check($sformatf("%s p%0d win_valid", tag, p), 72'(win_valid), 72'(tbl[p].vld));
      check($sformatf("%s p%0d col", tag, p), 72'(col), 72'(tbl[p].col));
      check($sformatf("%s p%0d row", tag, p), 72'(row), 72'(tbl[p].row));
      check($sformatf("%s p%0d frame_done", tag, p), 72'(frame_done), 72'(tbl[p].fd));
      if (tbl[p].vld || p == 14)
        check($sformatf("%s p%0d window", tag, p), window, tbl[p].win);
      if (win_valid) nvalid++;
      pc = tbl[p].col;
      pr = tbl[p].row;
    end
    check({tag, " valid count"}, 72'(nvalid), 72'(4));
  endtask

  // Streams n pixels of a fresh frame, then asserts reset between clock edges.
  task automatic async_reset_after(input int n, input logic exp_vld_before);
    for (int p = 0; p < n; p++) begin
      en   = 1'b1;
      data = tbl[p].pix;
      @(negedge clk);
    end
    en = 1'b0;
    check($sformatf("rst%0d valid before", n), 72'(win_valid), 72'(exp_vld_before));
    check($sformatf("rst%0d col before", n), 72'(col), 72'(tbl[n-1].col));
    #2 reset = 1'b1;
    #1;
    check($sformatf("rst%0d async win_valid", n), 72'(win_valid), 72'(0));
    check($sformatf("rst%0d async window", n), window, 72'(0));
    check($sformatf("rst%0d async col", n), 72'(col), 72'(0));
    check($sformatf("rst%0d async row", n), 72'(row), 72'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < W*H; p++) begin
      tbl[p].pix = 8'(p);
      tbl[p].col = 16'(p % W);
      tbl[p].row = 16'(p / W);
      tbl[p].vld = 1'b0;
      tbl[p].fd  = 1'b0;
      tbl[p].win = '0;
    end
    tbl[10].vld = 1'b1; tbl[10].win = mk_win(0, 1, 2, 4, 5, 6, 8, 9, 10);
    tbl[11].vld = 1'b1; tbl[11].win = mk_win(1, 2, 3, 5, 6, 7, 9, 10, 11);
    tbl[14].vld = 1'b1; tbl[14].win = mk_win(4, 5, 6, 8, 9, 10, 12, 13, 14);
    tbl[15].vld = 1'b1; tbl[15].win = mk_win(5, 6, 7, 9, 10, 11, 13, 14, 15);
    tbl[15].fd  = 1'b1;

    reset = 1'b1;
    en    = 1'b0;
    data  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset c%0d window", i), window, 72'(0));
      check($sformatf("reset c%0d win_valid", i), 72'(win_valid), 72'(0));
      check($sformatf("reset c%0d frame_done", i), 72'(frame_done), 72'(0));
      check($sformatf("reset c%0d col", i), 72'(col), 72'(0));
      check($sformatf("reset c%0d row", i), 72'(row), 72'(0));
    end
    reset = 1'b0;

    run_frame("f1", 1'b0);
    run_frame("f2", 1'b0);
    run_frame("gap", 1'b1);

    async_reset_after(6, 1'b0);
    run_frame("post6", 1'b0);

    async_reset_after(11, 1'b1);
    run_frame("post11", 1'b0);

    en = 1'b0;
    @(negedge clk);
    check("idle after frame frame_done", 72'(frame_done), 72'(0));
    check("idle after frame win_valid", 72'(win_valid), 72'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
